branch_redirect_unit: RTL and testbench

- Produces the program counter's control inputs: branch, branchaddress and stall.
- Resolves LEGv8 control-flow instructions (B, BR, CBZ, CBNZ, B.cond) arriving from the EX stage.
- Sequences pipeline flushes after a taken redirect and inserts load-use stall bubbles on request from ID.
- Sits between the EX/ID stages and the PC register, driving it from the responder side.

---
 rtl/legv8_pkg.sv | 44 ++++
 rtl/cond_eval.sv | 45 ++++
 rtl/branch_redirect_unit.sv | 176 +++++++++++++++++
 tb/tb_branch_redirect_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// legv8_pkg: shared types and defaults for the LEGv8 branch redirect logic.
//   ADDR_W_DEFAULT - default PC/address width
//   br_kind_t      - EX-stage control-flow kind encoding (6..7 decode as NONE)
//   cond_t         - ARM/LEGv8 B.cond condition codes 0x0..0xF
//   state_t        - redirect sequencer states
package legv8_pkg;

  localparam int ADDR_W_DEFAULT = 64;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_B     = 3'd1,
    BR_CBZ   = 3'd2,
    BR_CBNZ  = 3'd3,
    BR_BCOND = 3'd4,
    BR_BR    = 3'd5
  } br_kind_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_STALL = 2'd2
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational B.cond evaluator.
// Ports:
//   cond  [3:0] in  - condition code (cond_t)
//   flags [3:0] in  - NZCV, bit 3 = N, bit 0 = V
//   taken       out - condition holds for the given flags
// NV is treated the same as AL (always true).
module cond_eval
  import legv8_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n_flag, z_flag, c_flag, v_flag;

  assign n_flag = flags[3];
  assign z_flag = flags[2];
  assign c_flag = flags[1];
  assign v_flag = flags[0];

  always_comb begin
    taken = 1'b0;
    case (cond_t'(cond))
      COND_EQ: taken = z_flag;
      COND_NE: taken = !z_flag;
      COND_HS: taken = c_flag;
      COND_LO: taken = !c_flag;
      COND_MI: taken = n_flag;
      COND_PL: taken = !n_flag;
      COND_VS: taken = v_flag;
      COND_VC: taken = !v_flag;
      COND_HI: taken = c_flag && !z_flag;
      COND_LS: taken = !c_flag || z_flag;
      COND_GE: taken = (n_flag == v_flag);
      COND_LT: taken = (n_flag != v_flag);
      COND_GT: taken = !z_flag && (n_flag == v_flag);
      COND_LE: taken = z_flag || (n_flag != v_flag);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: resolves LEGv8 control flow from EX and drives the PC
// control inputs (branch strobe, redirect target, stall), plus the pipeline
// flush and a busy indication. All outputs are registered.
// Ports:
//   clock, reset (sync, active-high)
//   ex_valid, ex_kind[2:0], ex_pc, ex_imm[25:0], ex_rt_zero, ex_reg_target,
//   ex_cond[3:0], ex_flags[3:0]   - EX-stage instruction and operands
//   id_load_use                   - ID-stage load-use stall request
//   branch                        - one-cycle redirect strobe
//   branchaddress                 - redirect target, holds while branch=0
//   stall, flush, busy            - PC hold, IF/ID+ID/EX squash, state!=IDLE
// Optional build macro BRANCH_STATS_EN adds saturating 32-bit counters
// stat_taken / stat_not_taken over resolved (non-wrong-path) branches.
module branch_redirect_unit
  import legv8_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEFAULT,
  parameter int FLUSH_CYCLES   = 2,
  parameter int LOADUSE_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [2:0]        ex_kind,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [25:0]       ex_imm,
  input  logic              ex_rt_zero,
  input  logic [ADDR_W-1:0] ex_reg_target,
  input  logic [3:0]        ex_cond,
  input  logic [3:0]        ex_flags,
  input  logic              id_load_use,
  output logic              branch,
  output logic [ADDR_W-1:0] branchaddress,
  output logic              stall,
  output logic              flush,
  output logic              busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_taken,
  output logic [31:0]       stat_not_taken
`endif
);

  // Counters hold "remaining cycles minus one", so a sequence of N cycles
  // loads N-1 and exits when the counter reads zero.
  localparam logic [2:0] FLUSH_LOAD   = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LOADUSE_LOAD = 3'(LOADUSE_CYCLES - 1);

  state_t            state_reg;
  logic [2:0]        count_reg;

  logic              cond_taken;
  logic              resolved;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] imm26_ext;
  logic [ADDR_W-1:0] imm19_ext;
  logic              evaluate;
  logic              redirect;

  cond_eval u_cond_eval (
    .cond  (ex_cond),
    .flags (ex_flags),
    .taken (cond_taken)
  );

  assign imm26_ext = {{(ADDR_W-26){ex_imm[25]}}, ex_imm};
  assign imm19_ext = {{(ADDR_W-19){ex_imm[18]}}, ex_imm[18:0]};

  always_comb begin
    resolved = 1'b0;
    taken    = 1'b0;
    target   = ex_pc + (imm19_ext << 2);
    case (ex_kind)
      BR_B: begin
        resolved = 1'b1;
        taken    = 1'b1;
        target   = ex_pc + (imm26_ext << 2);
      end
      BR_CBZ: begin
        resolved = 1'b1;
        taken    = ex_rt_zero;
      end
      BR_CBNZ: begin
        resolved = 1'b1;
        taken    = !ex_rt_zero;
      end
      BR_BCOND: begin
        resolved = 1'b1;
        taken    = cond_taken;
      end
      BR_BR: begin
        resolved = 1'b1;
        taken    = 1'b1;
        target   = ex_reg_target & {{(ADDR_W-2){1'b1}}, 2'b00};
      end
      default: begin
        resolved = 1'b0;
        taken    = 1'b0;
      end
    endcase
  end

  // Anything arriving while flushing is wrong-path and must not resolve.
  // STALL still evaluates EX so a taken branch can preempt the bubble.
  assign evaluate = ex_valid && (state_reg != ST_FLUSH);
  assign redirect = evaluate && taken;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      count_reg     <= 3'd0;
      branch        <= 1'b0;
      branchaddress <= '0;
      stall         <= 1'b0;
      flush         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      branch <= 1'b0;
      case (state_reg)
        ST_FLUSH: begin
          if (count_reg == 3'd0) begin
            state_reg <= ST_IDLE;
            flush     <= 1'b0;
            busy      <= 1'b0;
          end else begin
            count_reg <= count_reg - 3'd1;
          end
        end
        default: begin
          // IDLE and STALL share the redirect path; a taken branch always
          // wins over any stall, pending or newly requested.
          if (redirect) begin
            state_reg     <= ST_FLUSH;
            count_reg     <= FLUSH_LOAD;
            branch        <= 1'b1;
            branchaddress <= target;
            flush         <= 1'b1;
            stall         <= 1'b0;
            busy          <= 1'b1;
          end else if (state_reg == ST_STALL) begin
            // New load-use requests are ignored here; ID re-asserts.
            if (count_reg == 3'd0) begin
              state_reg <= ST_IDLE;
              stall     <= 1'b0;
              busy      <= 1'b0;
            end else begin
              count_reg <= count_reg - 3'd1;
            end
          end else if (id_load_use) begin
            state_reg <= ST_STALL;
            count_reg <= LOADUSE_LOAD;
            stall     <= 1'b1;
            busy      <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_taken     <= 32'd0;
      stat_not_taken <= 32'd0;
    end else if (evaluate && resolved) begin
      if (taken) begin
        if (stat_taken != 32'hFFFF_FFFF) stat_taken <= stat_taken + 32'd1;
      end else begin
        if (stat_not_taken != 32'hFFFF_FFFF) stat_not_taken <= stat_not_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb_branch_redirect_unit: table-driven vectors, hand-written multi-cycle
// sequences and a randomized run, all checked against a cycle-count model.
module tb_branch_redirect_unit;

  localparam int AW = 64;
  localparam int FC = 2;
  localparam int LC = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          ex_valid;
  logic [2:0]    ex_kind;
  logic [AW-1:0] ex_pc;
  logic [25:0]   ex_imm;
  logic          ex_rt_zero;
  logic [AW-1:0] ex_reg_target;
  logic [3:0]    ex_cond;
  logic [3:0]    ex_flags;
  logic          id_load_use;
  logic          branch;
  logic [AW-1:0] branchaddress;
  logic          stall;
  logic          flush;
  logic          busy;

  int tests = 0;
  int fails = 0;

  // Reference model: remaining flush/stall cycles plus last redirect.
  int            m_flush = 0;
  int            m_stall = 0;
  logic          m_branch = 1'b0;
  logic [AW-1:0] m_addr = '0;

  branch_redirect_unit #(
    .ADDR_W(AW), .FLUSH_CYCLES(FC), .LOADUSE_CYCLES(LC)
  ) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_kind(ex_kind),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rt_zero(ex_rt_zero),
    .ex_reg_target(ex_reg_target), .ex_cond(ex_cond), .ex_flags(ex_flags),
    .id_load_use(id_load_use), .branch(branch), .branchaddress(branchaddress),
    .stall(stall), .flush(flush), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !(cc && !z);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit ref_taken(input logic [2:0] k, input logic rtz,
                                   input logic [3:0] c, input logic [3:0] f);
    case (k)
      3'd1, 3'd5: return 1'b1;
      3'd2: return rtz;
      3'd3: return !rtz;
      3'd4: return ref_cond(c, f);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [AW-1:0] ref_target(input logic [2:0] k, input logic [AW-1:0] pc,
                                               input logic [25:0] imm, input logic [AW-1:0] rt);
    longint off;
    if (k == 3'd5) return (rt >> 2) << 2;
    if (k == 3'd1) off = longint'($signed(imm));
    else           off = longint'($signed(imm[18:0]));
    return pc + 64'(off * 4);
  endfunction

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (reset) begin
      m_flush = 0; m_stall = 0; m_branch = 1'b0; m_addr = '0;
    end else begin
      m_branch = 1'b0;
      if (m_flush > 0) m_flush--;
      else if (ex_valid && ref_taken(ex_kind, ex_rt_zero, ex_cond, ex_flags)) begin
        m_branch = 1'b1;
        m_addr   = ref_target(ex_kind, ex_pc, ex_imm, ex_reg_target);
        m_flush  = FC;
        m_stall  = 0;
      end else if (m_stall > 0) m_stall--;
      else if (id_load_use) m_stall = LC;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".branch"}, 64'(branch), 64'(m_branch));
    check({tag, ".addr"},   branchaddress, m_addr);
    check({tag, ".flush"},  64'(flush), 64'(m_flush > 0));
    check({tag, ".stall"},  64'(stall), 64'(m_stall > 0));
    check({tag, ".busy"},   64'(busy), 64'((m_flush > 0) || (m_stall > 0)));
  endtask

  task automatic drive(input logic v, input logic [2:0] k, input logic [AW-1:0] pc,
                       input logic [25:0] imm, input logic rtz, input logic [AW-1:0] rt,
                       input logic [3:0] c, input logic [3:0] f, input logic lu);
    ex_valid = v; ex_kind = k; ex_pc = pc; ex_imm = imm; ex_rt_zero = rtz;
    ex_reg_target = rt; ex_cond = c; ex_flags = f; id_load_use = lu;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, '0, '0, 1'b0, '0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic drain(input string tag);
    idle();
    for (int k = 0; k < 20 && busy; k++) step();
    check({tag, ".drain_busy"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic          valid;
    logic [2:0]    kind;
    logic [AW-1:0] pc;
    logic [25:0]   imm;
    logic          rtz;
    logic [AW-1:0] regt;
    logic [3:0]    cond;
    logic [3:0]    flags;
    logic          lu;
    logic          e_branch;
    logic [AW-1:0] e_addr;
    logic          e_flush;
    logic          e_stall;
  } vec_t;

  vec_t vecs[14];

  initial begin
    //            v  kind  pc                      imm           rtz regt       cond  flags  lu  br  addr                    fl  st
    vecs[0]  = '{1, 3'd1, 64'h100,                26'h3FFFFFF, 0, 64'h0,    4'h0, 4'h0,  0,  1, 64'hFC,                 1,  0};
    vecs[1]  = '{1, 3'd2, 64'h40,                 26'h4,       0, 64'h0,    4'h0, 4'h0,  0,  0, 64'h0,                  0,  0};
    vecs[2]  = '{1, 3'd2, 64'h40,                 26'h4,       1, 64'h0,    4'h0, 4'h0,  0,  1, 64'h50,                 1,  0};
    vecs[3]  = '{1, 3'd4, 64'h200,                26'h2A7FFFE, 0, 64'h0,    4'hA, 4'b1000, 0, 0, 64'h0,                 0,  0};
    vecs[4]  = '{1, 3'd4, 64'h200,                26'h2A7FFFE, 0, 64'h0,    4'hA, 4'b1001, 0, 1, 64'h1F8,               1,  0};
    vecs[5]  = '{1, 3'd1, 64'hFFFFFFFFFFFFFFFC,   26'h2,       0, 64'h0,    4'h0, 4'h0,  0,  1, 64'h4,                  1,  0};
    vecs[6]  = '{1, 3'd5, 64'h800,                26'h123,     0, 64'h1003, 4'h0, 4'h0,  0,  1, 64'h1000,               1,  0};
    vecs[7]  = '{0, 3'd0, 64'h0,                  26'h0,       0, 64'h0,    4'h0, 4'h0,  1,  0, 64'h0,                  0,  1};
    vecs[8]  = '{1, 3'd1, 64'h300,                26'h10,      0, 64'h0,    4'h0, 4'h0,  1,  1, 64'h340,                1,  0};
    vecs[9]  = '{1, 3'd6, 64'h300,                26'h10,      0, 64'h0,    4'hE, 4'h0,  0,  0, 64'h0,                  0,  0};
    vecs[10] = '{0, 3'd1, 64'h300,                26'h10,      0, 64'h0,    4'h0, 4'h0,  0,  0, 64'h0,                  0,  0};
    vecs[11] = '{1, 3'd3, 64'h1000,               26'h0040000, 0, 64'h0,    4'h0, 4'h0,  0,  1, 64'hFFFFFFFFFFF01000,   1,  0};
    vecs[12] = '{1, 3'd4, 64'h0,                  26'h1,       0, 64'h0,    4'h0, 4'b0100, 0, 1, 64'h4,                 1,  0};
    vecs[13] = '{1, 3'd7, 64'h0,                  26'h1,       1, 64'h0,    4'hE, 4'h0,  1,  0, 64'h0,                  0,  1};

    // Reset state
    idle();
    reset = 1'b1;
    step(); step();
    check("reset.branch", 64'(branch), 64'd0);
    check("reset.addr",   branchaddress, 64'd0);
    check("reset.flush",  64'(flush), 64'd0);
    check("reset.stall",  64'(stall), 64'd0);
    check("reset.busy",   64'(busy), 64'd0);
    reset = 1'b0;
    step();

    // Table vectors, each applied from IDLE for one cycle
    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].kind, vecs[i].pc, vecs[i].imm, vecs[i].rtz,
            vecs[i].regt, vecs[i].cond, vecs[i].flags, vecs[i].lu);
      step();
      idle();
      check($sformatf("vec%0d.branch", i), 64'(branch), 64'(vecs[i].e_branch));
      if (vecs[i].e_branch)
        check($sformatf("vec%0d.addr", i), branchaddress, vecs[i].e_addr);
      check($sformatf("vec%0d.flush", i), 64'(flush), 64'(vecs[i].e_flush));
      check($sformatf("vec%0d.stall", i), 64'(stall), 64'(vecs[i].e_stall));
      check($sformatf("vec%0d.busy", i), 64'(busy), 64'(vecs[i].e_flush | vecs[i].e_stall));
      drain($sformatf("vec%0d", i));
    end

    // Flush length after a taken B, then busy clears
    drive(1, 3'd1, 64'h100, 26'h3FFFFFF, 0, '0, 4'h0, 4'h0, 0);
    step(); idle();
    check("flushlen.branch1", 64'(branch), 64'd1);
    check("flushlen.addr", branchaddress, 64'hFC);
    for (int c = 1; c < FC; c++) begin
      step();
      check($sformatf("flushlen.c%0d.flush", c), 64'(flush), 64'd1);
      check($sformatf("flushlen.c%0d.branch", c), 64'(branch), 64'd0);
    end
    step();
    check("flushlen.end.flush", 64'(flush), 64'd0);
    check("flushlen.end.busy", 64'(busy), 64'd0);

    // Taken branch presented during FLUSH is ignored
    drive(1, 3'd1, 64'h100, 26'h1, 0, '0, 4'h0, 4'h0, 0);
    step();
    check("inflush.first", 64'(branch), 64'd1);
    drive(1, 3'd1, 64'h500, 26'h1, 0, '0, 4'h0, 4'h0, 1);
    for (int c = 0; c < FC; c++) begin
      step();
      check($sformatf("inflush.c%0d.branch", c), 64'(branch), 64'd0);
      check($sformatf("inflush.c%0d.stall", c), 64'(stall), 64'd0);
    end
    check("inflush.addr_held", branchaddress, 64'h104);
    drain("inflush");

    // Load-use stall lasts exactly LOADUSE_CYCLES
    drive(0, 3'd0, '0, '0, 0, '0, 4'h0, 4'h0, 1);
    step(); idle();
    for (int c = 0; c < LC; c++) begin
      check($sformatf("stall.c%0d", c), 64'(stall), 64'd1);
      if (c < LC - 1) step();
    end
    step();
    check("stall.end", 64'(stall), 64'd0);
    check("stall.end_busy", 64'(busy), 64'd0);

    // Taken branch during STALL preempts the stall
    drive(0, 3'd0, '0, '0, 0, '0, 4'h0, 4'h0, 1);
    step();
    check("preempt.stall", 64'(stall), 64'd1);
    drive(1, 3'd5, '0, '0, 0, 64'h2002, 4'h0, 4'h0, 0);
    step(); idle();
    check("preempt.branch", 64'(branch), 64'd1);
    check("preempt.addr", branchaddress, 64'h2000);
    check("preempt.stall_drop", 64'(stall), 64'd0);
    check("preempt.flush", 64'(flush), 64'd1);
    drain("preempt");

    // Reset in the middle of FLUSH
    drive(1, 3'd1, 64'h100, 26'h8, 0, '0, 4'h0, 4'h0, 0);
    step(); idle();
    check("midreset.branch_pre", 64'(branch), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset.branch", 64'(branch), 64'd0);
    check("midreset.addr", branchaddress, 64'd0);
    check("midreset.flush", 64'(flush), 64'd0);
    check("midreset.stall", 64'(stall), 64'd0);
    check("midreset.busy", 64'(busy), 64'd0);

    // B.cond sweep of all 16 codes against the model
    for (int c = 0; c < 16; c++) begin
      for (int r = 0; r < 4; r++) begin
        drive(1, 3'd4, {$urandom, $urandom}, 26'($urandom), 0, '0, 4'(c), 4'($urandom), 0);
        step(); idle();
        check_model($sformatf("bcond.c%0d.r%0d", c, r));
        for (int k = 0; k < 20 && busy; k++) step();
        check_model($sformatf("bcond.c%0d.r%0d.drained", c, r));
      end
    end

    // Randomized run against the model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            {$urandom, $urandom}, 26'($urandom), 1'($urandom), {$urandom, $urandom},
            4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0);
      step();
      check_model($sformatf("rand%0d", n));
    end
    reset = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
